// File: rtl/xor_logic_arbiter_if.sv
// ----------------------------------------------------------------------------
// xor_logic_arbiter_if
//   Bundles the requester handshakes, the output handshake and the key
//   programming port of xor_logic_arbiter. Clock and reset are not carried
//   here; they stay plain ports on the module.
//
//   Signals:
//     ivG_req_valid  PAR_REQ               per-requester valid
//     ivG_req_data   PAR_REQ*PAR_DATA_BITS requester i data in [i*W +: W]
//     ovG_req_ready  PAR_REQ               per-requester ready (one-hot or zero)
//     ob_out_valid   1                     output word valid
//     ib_out_ready   1                     downstream accepts output word
//     ovG_out_data   PAR_DATA_BITS         granted data XOR key
//     ovG_out_id     PAR_ID_BITS           index of granted requester
//     ib_key_wr      1                     key write strobe
//     ivG_key        PAR_DATA_BITS         new key value
//     ovG_key        PAR_DATA_BITS         current key register
//
//   Modports: slave = arbiter view, master = producer/consumer side.
// ----------------------------------------------------------------------------
interface xor_logic_arbiter_if #(
    parameter int PAR_DATA_BITS = 16,
    parameter int PAR_REQ       = 4,
    parameter int PAR_ID_BITS   = 2
);
    logic [PAR_REQ-1:0]               ivG_req_valid;
    logic [PAR_REQ*PAR_DATA_BITS-1:0] ivG_req_data;
    logic [PAR_REQ-1:0]               ovG_req_ready;
    logic                             ob_out_valid;
    logic                             ib_out_ready;
    logic [PAR_DATA_BITS-1:0]         ovG_out_data;
    logic [PAR_ID_BITS-1:0]           ovG_out_id;
    logic                             ib_key_wr;
    logic [PAR_DATA_BITS-1:0]         ivG_key;
    logic [PAR_DATA_BITS-1:0]         ovG_key;

    modport slave (
        input  ivG_req_valid, ivG_req_data, ib_out_ready, ib_key_wr, ivG_key,
        output ovG_req_ready, ob_out_valid, ovG_out_data, ovG_out_id, ovG_key
    );

    modport master (
        output ivG_req_valid, ivG_req_data, ib_out_ready, ib_key_wr, ivG_key,
        input  ovG_req_ready, ob_out_valid, ovG_out_data, ovG_out_id, ovG_key
    );
endinterface

// File: rtl/xor_logic_arbiter.sv
// ----------------------------------------------------------------------------
// xor_logic_arbiter
//   Round-robin arbiter sharing one registered XOR-scrambling stage between
//   PAR_REQ requesters. The granted word is XORed with a runtime-writable key
//   and held in a one-entry output register until the consumer takes it.
//
//   Ports:
//     ib_clk  clock, all logic on the rising edge
//     ib_rst  synchronous reset, active-high
//     bus     xor_logic_arbiter_if.slave (request, output and key signals)
// ----------------------------------------------------------------------------
module xor_logic_arbiter #(
    parameter int                     PAR_DATA_BITS = 16,
    parameter int                     PAR_REQ       = 4,
    parameter int                     PAR_ID_BITS   = 2,
    parameter logic [PAR_DATA_BITS-1:0] PAR_XOR     = 16'hA5A5
) (
    input  logic                  ib_clk,
    input  logic                  ib_rst,
    xor_logic_arbiter_if.slave    bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                   state, state_nxt;
    logic [PAR_ID_BITS-1:0]   ptr;
    logic [PAR_DATA_BITS-1:0] key;
    logic [PAR_DATA_BITS-1:0] out_data;
    logic [PAR_ID_BITS-1:0]   out_id;

    logic                     can_take;
    logic                     grant_vld;
    logic [PAR_ID_BITS-1:0]   grant_idx;
    logic [PAR_DATA_BITS-1:0] grant_data;
    int                       idx;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        can_take   = (state == IDLE) || bus.ib_out_ready;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        idx        = 0;
        // Search ptr, ptr+1, ... wrapping; the first valid requester wins.
        for (int k = 0; k < PAR_REQ; k++) begin
            idx = (int'(ptr) + k) % PAR_REQ;
            if (!grant_vld && bus.ivG_req_valid[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = PAR_ID_BITS'(idx);
                grant_data = bus.ivG_req_data[idx*PAR_DATA_BITS +: PAR_DATA_BITS];
            end
        end
        // Ready must never be offered while the stage is full or in reset.
        if (ib_rst || !can_take) begin
            grant_vld = 1'b0;
        end

        state_nxt = state;
        case (state)
            IDLE: if (grant_vld) state_nxt = HOLD;
            HOLD: if (bus.ib_out_ready && !grant_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge ib_clk) begin
        if (ib_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge ib_clk) begin
        if (ib_rst) begin
            ptr      <= '0;
            key      <= PAR_XOR;
            out_data <= '0;
            out_id   <= '0;
        end else begin
            if (grant_vld) begin
                // Captured with the key in effect before any write this edge.
                out_data <= grant_data ^ key;
                out_id   <= grant_idx;
                ptr      <= (grant_idx == PAR_ID_BITS'(PAR_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (bus.ib_key_wr) begin
                key <= bus.ivG_key;
            end
        end
    end

    assign bus.ovG_req_ready = grant_vld ? (PAR_REQ'(1) << grant_idx) : '0;
    assign bus.ob_out_valid  = (state == HOLD);
    assign bus.ovG_out_data  = out_data;
    assign bus.ovG_out_id    = out_id;
    assign bus.ovG_key       = key;

endmodule

// File: tb/tb_xor_logic_arbiter.sv
// ----------------------------------------------------------------------------
// tb_xor_logic_arbiter
//   Self-checking bench for xor_logic_arbiter (4 requesters, 16-bit data,
//   reset key A5A5). A transaction-level model tracks the output slot, the
//   key and the round-robin pointer; directed scenarios are followed by a
//   randomized run.
// ----------------------------------------------------------------------------
module tb_xor_logic_arbiter;
    localparam int REQ = 4;
    localparam int W   = 16;
    localparam int IDB = 2;
    localparam logic [W-1:0] KEY0 = 16'hA5A5;

    logic ib_clk = 1'b0;
    logic ib_rst = 1'b1;
    always #5 ib_clk = ~ib_clk;

    xor_logic_arbiter_if #(.PAR_DATA_BITS(W), .PAR_REQ(REQ), .PAR_ID_BITS(IDB)) bus ();

    xor_logic_arbiter #(
        .PAR_DATA_BITS(W), .PAR_REQ(REQ), .PAR_ID_BITS(IDB), .PAR_XOR(KEY0)
    ) dut (
        .ib_clk (ib_clk),
        .ib_rst (ib_rst),
        .bus    (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: contents of the single output slot, key, rr pointer.
    bit           m_full = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_id   = 0;
    logic [W-1:0] m_key  = KEY0;
    int           m_ptr  = 0;
    logic [REQ-1:0] last_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, compare everything, advance model.
    task automatic cycle(input logic [REQ-1:0] v, input logic [REQ*W-1:0] d,
                         input logic ordy, input logic kwr, input logic [W-1:0] k,
                         input logic rst);
        int g;
        logic [REQ-1:0] exp_ready;
        @(negedge ib_clk);
        ib_rst            = rst;
        bus.ivG_req_valid = v;
        bus.ivG_req_data  = d;
        bus.ib_out_ready  = ordy;
        bus.ib_key_wr     = kwr;
        bus.ivG_key       = k;
        #1;
        g = -1;
        if (!rst && (!m_full || ordy)) begin
            for (int j = 0; j < REQ; j++) begin
                int i;
                i = (m_ptr + j) % REQ;
                if (g < 0 && v[i]) g = i;
            end
        end
        exp_ready = (g < 0) ? '0 : REQ'(1 << g);
        last_ready = bus.ovG_req_ready;
        check("ready",     bus.ovG_req_ready, exp_ready);
        check("out_valid", bus.ob_out_valid,  m_full);
        check("out_data",  bus.ovG_out_data,  m_data);
        check("out_id",    bus.ovG_out_id,    m_id);
        check("key",       bus.ovG_key,       m_key);
        if (rst) begin
            m_full = 0; m_data = '0; m_id = 0; m_key = KEY0; m_ptr = 0;
        end else begin
            if (g >= 0) begin
                m_data = d[g*W +: W] ^ m_key;
                m_id   = g;
                m_full = 1;
                m_ptr  = (g + 1) % REQ;
            end else if (m_full && ordy) begin
                m_full = 0;
            end
            if (kwr) m_key = k;
        end
        @(posedge ib_clk);
        #2;
    endtask

    function automatic logic [REQ*W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [REQ*W-1:0] d;
        bus.ivG_req_valid = '1;
        bus.ivG_req_data  = '0;
        bus.ib_out_ready  = 1'b1;
        bus.ib_key_wr     = 1'b0;
        bus.ivG_key       = '0;
        // Bring registers out of X before the model takes over.
        repeat (2) @(posedge ib_clk);

        // 1: reset held 3 cycles with every requester valid.
        repeat (3) cycle('1, rnd_data(), 1'b1, 1'b0, '0, 1'b1);
        check("t1_ready", last_ready, 4'b0000);
        check("t1_key",   bus.ovG_key, 16'hA5A5);

        // 2: single request from requester 2.
        d = '0; d[2*W +: W] = 16'h1234;
        cycle(4'b0100, d, 1'b1, 1'b0, '0, 1'b0);
        check("t2_ready", last_ready, 4'b0100);
        check("t2_valid", bus.ob_out_valid, 1'b1);
        check("t2_data",  bus.ovG_out_data, 16'hB791);
        check("t2_id",    bus.ovG_out_id, 2);
        cycle(4'b0000, d, 1'b1, 1'b0, '0, 1'b0);
        check("t2_drain", bus.ob_out_valid, 1'b0);

        // 3: all valid from a fresh pointer -> ids 0,1,2,3,0,1 back to back.
        cycle('0, '0, 1'b1, 1'b0, '0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            cycle('1, rnd_data(), 1'b1, 1'b0, '0, 1'b0);
            check("t3_valid", bus.ob_out_valid, 1'b1);
            check("t3_id",    bus.ovG_out_id, n % REQ);
        end

        // 4: backpressure for 5 cycles, then release.
        for (int n = 0; n < 5; n++) begin
            cycle('1, rnd_data(), 1'b0, 1'b0, '0, 1'b0);
            check("t4_ready", last_ready, 4'b0000);
            check("t4_id",    bus.ovG_out_id, 1);
        end
        cycle('1, rnd_data(), 1'b1, 1'b0, '0, 1'b0);
        check("t4_rel_id", bus.ovG_out_id, 2);
        cycle('1, rnd_data(), 1'b1, 1'b0, '0, 1'b0);
        check("t4_next_id", bus.ovG_out_id, 3);

        // 5: key write then capture; write and capture in the same cycle.
        cycle('0, '0, 1'b1, 1'b0, '0, 1'b1);
        d = '0; d[0 +: W] = 16'h1234;
        cycle(4'b0001, d, 1'b1, 1'b1, 16'h00FF, 1'b0);
        check("t5_oldkey", bus.ovG_out_data, 16'hB791);
        cycle(4'b0001, d, 1'b1, 1'b0, '0, 1'b0);
        check("t5_newkey", bus.ovG_out_data, 16'h12CB);

        // 6: reset while a word is held under backpressure.
        cycle(4'b0010, rnd_data(), 1'b0, 1'b0, '0, 1'b0);
        cycle('1, rnd_data(), 1'b0, 1'b1, 16'h1111, 1'b0);
        check("t6_hold", bus.ob_out_valid, 1'b1);
        cycle('1, rnd_data(), 1'b0, 1'b0, '0, 1'b1);
        check("t6_valid", bus.ob_out_valid, 1'b0);
        check("t6_key",   bus.ovG_key, 16'hA5A5);
        cycle('1, rnd_data(), 1'b1, 1'b0, '0, 1'b0);
        check("t6_ptr0",  bus.ovG_out_id, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(REQ'($urandom), rnd_data(), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0), W'($urandom),
                  ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
